// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache. Hits complete combinationally (zero stall).
// A miss holds ready low through an optional write-back and a refill, then completes as a hit.
module dcache_responder #(
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int LINE_BITS    = 32 << OFFSET_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic                 r_valid,
  input  logic                 w_valid,
  input  logic [31:0]          w_data,
  output logic                 r_ready,
  output logic                 w_ready,
  output logic [31:0]          r_data,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [31:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int TAG_WIDTH = 30 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  logic [OFFSET_WIDTH-1:0] offset;
  logic [INDEX_WIDTH-1:0]  index;
  logic [TAG_WIDTH-1:0]    tag;
  logic                    unused_addr_bits;

  assign offset           = addr[OFFSET_WIDTH+1:2];
  assign index            = addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
  assign tag              = addr[31 -: TAG_WIDTH];
  assign unused_addr_bits = ^addr[1:0];

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [LINE_BITS-1:0] data_mem [LINES];

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] miss_index_q;
  logic [TAG_WIDTH-1:0]   miss_tag_q;

  logic                 hit;
  logic                 req;
  logic                 miss;
  logic [LINE_BITS-1:0] cur_line;

  assign cur_line = data_mem[index];
  assign hit      = valid_q[index] && (tag_mem[index] == tag);
  assign req      = r_valid || w_valid;

  // Miss index/tag are latched so memory outputs stay stable even if the CPU drops its request.
  always_comb begin
    state_d   = state_q;
    r_ready   = 1'b0;
    w_ready   = 1'b0;
    miss      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = data_mem[miss_index_q];
    r_data    = cur_line[offset*32 +: 32];
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // Simultaneous read and write is illegal; the write wins.
            if (w_valid) w_ready = 1'b1;
            else         r_ready = 1'b1;
          end else begin
            miss    = 1'b1;
            state_d = (valid_q[index] && dirty_q[index]) ? WB : REFILL;
          end
        end
      end
      WB: begin
        mem_wr   = 1'b1;
        mem_addr = {tag_mem[miss_index_q], miss_index_q, {(OFFSET_WIDTH+2){1'b0}}};
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        mem_rd   = 1'b1;
        mem_addr = {miss_tag_q, miss_index_q, {(OFFSET_WIDTH+2){1'b0}}};
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      state_q <= state_d;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
      if (r_ready || w_ready) hit_cnt <= hit_cnt + 32'd1;
      if (w_ready) dirty_q[index] <= 1'b1;
      if (state_q == WB && mem_ready) dirty_q[miss_index_q] <= 1'b0;
      if (state_q == REFILL && mem_ready) begin
        valid_q[miss_index_q] <= 1'b1;
        dirty_q[miss_index_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (miss) begin
      miss_index_q <= index;
      miss_tag_q   <= tag;
    end
    if (!rst && w_ready) data_mem[index][offset*32 +: 32] <= w_data;
    if (!rst && state_q == REFILL && mem_ready) begin
      data_mem[miss_index_q] <= mem_rdata;
      tag_mem[miss_index_q]  <= miss_tag_q;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: hit table plus hand-written miss, eviction, drop and reset sequences.
module tb_dcache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic         r_valid, w_valid;
  logic [31:0]  w_data;
  logic         r_ready, w_ready;
  logic [31:0]  r_data;
  logic         mem_rd, mem_wr;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .r_valid(r_valid), .w_valid(w_valid),
    .w_data(w_data), .r_ready(r_ready), .w_ready(w_ready), .r_data(r_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic        rv;
    logic        wv;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_rr;
    logic        exp_wr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic wv, input logic [31:0] a, input logic [31:0] wd);
    r_valid = rv;
    w_valid = wv;
    addr    = a;
    w_data  = wd;
    #1;
  endtask

  // Waits for a memory request, checks it, holds it for lat cycles, then pulses mem_ready.
  task automatic mem_serve(input string name, input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [127:0] rdata, input int lat, output logic [127:0] wdata_seen);
    int n = 0;
    while (!(mem_rd || mem_wr) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL %s_timeout: got no memory request, required one within 20 cycles", name);
    end
    chk({name, "_mem_wr"}, {31'h0, mem_wr}, {31'h0, exp_wr});
    chk({name, "_mem_rd"}, {31'h0, mem_rd}, {31'h0, ~exp_wr});
    chk({name, "_mem_addr"}, mem_addr, exp_addr);
    wdata_seen = mem_wdata;
    repeat (lat) tick();
    chk({name, "_addr_held"}, mem_addr, exp_addr);
    mem_rdata = rdata;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  localparam logic [127:0] L1 = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};
  localparam logic [127:0] L2 = {32'hA333_0003, 32'hA222_0002, 32'hA111_0001, 32'hA000_0000};
  localparam logic [127:0] L3 = {32'h0F0F_0003, 32'h0F0F_0002, 32'h0F0F_0001, 32'h0F0F_0000};
  localparam logic [127:0] L4 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] wd_seen;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,         1'b1, 1'b0, 32'h2222_2222};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,         1'b1, 1'b0, 32'h3333_3333};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 1'b0, 32'h1234_5678};

    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_r_ready", {31'h0, r_ready}, 32'h0);
    chk("rst_w_ready", {31'h0, w_ready}, 32'h0);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);

    // Cold read miss with clean victim.
    drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    chk("cold_no_ready", {31'h0, r_ready}, 32'h0);
    tick();
    chk("cold_miss_cnt", miss_cnt, 32'd1);
    mem_serve("cold", 1'b0, 32'h0000_1000, L1, 2, wd_seen);
    chk("cold_r_ready", {31'h0, r_ready}, 32'h1);
    chk("cold_r_data", r_data, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("cold_hit_cnt", hit_cnt, 32'd1);

    // Hits, including the simultaneous read/write case.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].rv, vecs[i].wv, vecs[i].a, vecs[i].wd);
      chk($sformatf("vec%0d_r_ready", i), {31'h0, r_ready}, {31'h0, vecs[i].exp_rr});
      chk($sformatf("vec%0d_w_ready", i), {31'h0, w_ready}, {31'h0, vecs[i].exp_wr});
      chk($sformatf("vec%0d_mem_rd", i), {31'h0, mem_rd}, 32'h0);
      if (vecs[i].exp_rr) chk($sformatf("vec%0d_r_data", i), r_data, vecs[i].exp_rd);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    chk("table_hit_cnt", hit_cnt, 32'd8);
    chk("table_miss_cnt", miss_cnt, 32'd1);

    // Dirty eviction: write-back of the 0x1000 line, then refill of 0x2000.
    drive(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    chk("evict_no_ready", {31'h0, r_ready}, 32'h0);
    tick();
    chk("evict_miss_cnt", miss_cnt, 32'd2);
    mem_serve("evict_wb", 1'b1, 32'h0000_1000, '0, 1, wd_seen);
    chk("evict_wdata_w0", wd_seen[31:0], 32'h1234_5678);
    chk("evict_wdata_w1", wd_seen[63:32], 32'hCAFE_F00D);
    chk("evict_wdata_w2", wd_seen[95:64], 32'h2222_2222);
    chk("evict_no_ready_wb", {31'h0, r_ready}, 32'h0);
    mem_serve("evict_rf", 1'b0, 32'h0000_2000, L2, 0, wd_seen);
    chk("evict_r_ready", {31'h0, r_ready}, 32'h1);
    chk("evict_r_data", r_data, 32'hA000_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Write miss allocate with a clean (invalid) victim.
    drive(1'b0, 1'b1, 32'h0000_3010, 32'hA5A5_A5A5);
    chk("wmiss_no_ready", {31'h0, w_ready}, 32'h0);
    tick();
    chk("wmiss_miss_cnt", miss_cnt, 32'd3);
    mem_serve("wmiss", 1'b0, 32'h0000_3010, L3, 1, wd_seen);
    chk("wmiss_w_ready", {31'h0, w_ready}, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h0000_3010, 32'h0);
    chk("wmiss_rd_ready", {31'h0, r_ready}, 32'h1);
    chk("wmiss_rd_data", r_data, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 1'b0, 32'h0000_3014, 32'h0);
    chk("wmiss_rd1_data", r_data, 32'h0F0F_0001);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Dropped request: refill completes, no ready, line becomes valid.
    drive(1'b1, 1'b0, 32'h0000_4020, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_serve("drop", 1'b0, 32'h0000_4020, L4, 1, wd_seen);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drop_no_ready%0d", i), {31'h0, r_ready}, 32'h0);
      chk($sformatf("drop_no_mem%0d", i), {30'h0, mem_rd, mem_wr}, 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0000_4024, 32'h0);
    chk("drop_hit_ready", {31'h0, r_ready}, 32'h1);
    chk("drop_hit_data", r_data, 32'h4444_0001);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_hit_cnt", hit_cnt, 32'd13);
    chk("pre_rst_miss_cnt", miss_cnt, 32'd4);

    // Reset during refill aborts the transaction and invalidates all lines.
    drive(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    tick();
    chk("rstmid_mem_rd_before", {31'h0, mem_rd}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rstmid_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rstmid_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rstmid_hit_cnt", hit_cnt, 32'h0);
    chk("rstmid_miss_cnt", miss_cnt, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_1008, 32'h0);
    chk("rstmid_reread_miss", {31'h0, r_ready}, 32'h0);
    tick();
    chk("rstmid_reread_miss_cnt", miss_cnt, 32'd1);
    mem_serve("rstmid", 1'b0, 32'h0000_1000, L1, 0, wd_seen);
    chk("rstmid_r_ready", {31'h0, r_ready}, 32'h1);
    chk("rstmid_r_data", r_data, 32'h2222_2222);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rstmid_hit_cnt_end", hit_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
